// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
//
// Shares one 16-bit BRAM between the fx68k bus and the SPI loader port. The
// CPU always wins in IDLE. SPI byte requests are buffered in a 2-entry queue
// and are served in the IDLE cycles that have no CPU request.
//
// Ports:
//   clk, reset_n            system clock, async active-low reset
//   cpu_as_n, cpu_rw        68k address strobe, 1 = read / 0 = write
//   cpu_uds_n, cpu_lds_n    68k upper (even) / lower (odd) byte strobes
//   cpu_a[23:1]             68k word address
//   cpu_dout / cpu_din      CPU write data / registered read data to CPU
//   dtack_n                 data transfer acknowledge
//   spi_wr, spi_rd          one-cycle SPI write / read requests
//   spi_addr, spi_di        SPI byte address, SPI write byte
//   spi_do, spi_do_valid    SPI read byte and its one-cycle valid pulse
//   spi_overflow            sticky: a request was dropped because the queue was full
//   mem_addr, mem_we        BRAM word address, byte write enables {upper, lower}
//   mem_din, mem_dout       BRAM write data, BRAM read data
module cpu_mem_arbiter #(
    parameter int unsigned ADDR_BITS  = 15,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [7:0]  SPI_PAGE   = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_as_n,
    input  logic                 cpu_rw,
    input  logic                 cpu_uds_n,
    input  logic                 cpu_lds_n,
    input  logic [23:1]          cpu_a,
    input  logic [15:0]          cpu_dout,
    output logic [15:0]          cpu_din,
    output logic                 dtack_n,
    input  logic                 spi_wr,
    input  logic                 spi_rd,
    input  logic [31:0]          spi_addr,
    input  logic [7:0]           spi_di,
    output logic [7:0]           spi_do,
    output logic                 spi_do_valid,
    output logic                 spi_overflow,
    output logic [ADDR_BITS-2:0] mem_addr,
    output logic [1:0]           mem_we,
    output logic [15:0]          mem_din,
    input  logic [15:0]          mem_dout
);

    typedef enum logic [1:0] {StIdle, StCpuAcc, StCpuAck, StSpiAcc} state_e;

    typedef struct packed {
        logic                 op_wr;
        logic [ADDR_BITS-1:0] addr;
        logic [7:0]           data;
    } spi_req_t;

    localparam logic [1:0] LatInit = 2'(RD_LATENCY);

    state_e               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 cpu_served_q, cpu_served_d;
    logic                 dtack_n_q, dtack_n_d;
    logic [15:0]          cpu_din_q, cpu_din_d;
    logic [ADDR_BITS-2:0] mem_addr_q, mem_addr_d;
    logic [1:0]           mem_we_q, mem_we_d;
    logic [15:0]          mem_din_q, mem_din_d;
    logic [7:0]           spi_do_q, spi_do_d;
    logic                 spi_do_valid_q, spi_do_valid_d;
    logic                 spi_ovf_q, spi_ovf_d;
    // Kind and byte lane of the SPI access currently in flight.
    logic                 spi_op_wr_q, spi_op_wr_d;
    logic                 spi_lsb_q, spi_lsb_d;

    // Queue: entry 0 is the head, popping shifts entry 1 down.
    spi_req_t [1:0]       q_q, q_d;
    logic [1:0]           q_cnt_q, q_cnt_d;
    logic                 q_pop;
    logic                 q_push;
    spi_req_t             q_new;

    logic                 cpu_req;
    logic                 cpu_mapped;
    logic                 unused_spi_addr;

    assign unused_spi_addr = ^spi_addr[23:ADDR_BITS];

    assign cpu_req    = ~cpu_as_n & (~cpu_uds_n | ~cpu_lds_n) & ~cpu_served_q;
    assign cpu_mapped = (cpu_a[23:ADDR_BITS] == '0);

    always_comb begin
        q_push      = (spi_wr | spi_rd) && (spi_addr[31:24] == SPI_PAGE);
        // A simultaneous write and read resolve to the write.
        q_new.op_wr = spi_wr;
        q_new.addr  = spi_addr[ADDR_BITS-1:0];
        q_new.data  = spi_di;
        q_d         = q_q;
        q_cnt_d     = q_cnt_q;
        spi_ovf_d   = spi_ovf_q;
        if (q_pop) begin
            q_d[0]  = q_q[1];
            q_cnt_d = q_cnt_q - 2'd1;
        end
        if (q_push) begin
            if (q_cnt_q == 2'd2) begin
                spi_ovf_d = 1'b1;
            end else begin
                q_d[q_cnt_d[0]] = q_new;
                q_cnt_d         = q_cnt_d + 2'd1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cpu_served_d   = cpu_served_q;
        dtack_n_d      = dtack_n_q;
        cpu_din_d      = cpu_din_q;
        mem_addr_d     = mem_addr_q;
        mem_we_d       = 2'b00;  // write enables last only one cycle
        mem_din_d      = mem_din_q;
        spi_do_d       = spi_do_q;
        spi_do_valid_d = 1'b0;
        spi_op_wr_d    = spi_op_wr_q;
        spi_lsb_d      = spi_lsb_q;
        q_pop          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    if (cpu_mapped) begin
                        mem_addr_d = cpu_a[ADDR_BITS-1:1];
                        mem_din_d  = cpu_dout;
                        mem_we_d   = cpu_rw ? 2'b00 : {~cpu_uds_n, ~cpu_lds_n};
                        cnt_d      = LatInit;
                        state_d    = StCpuAcc;
                    end else begin
                        // Unmapped: acknowledge at once with open-bus data.
                        cpu_din_d = 16'hFFFF;
                        dtack_n_d = 1'b0;
                        state_d   = StCpuAck;
                    end
                end else if (q_cnt_q != 2'd0) begin
                    q_pop       = 1'b1;
                    mem_addr_d  = q_q[0].addr[ADDR_BITS-1:1];
                    spi_op_wr_d = q_q[0].op_wr;
                    spi_lsb_d   = q_q[0].addr[0];
                    if (q_q[0].op_wr) begin
                        mem_din_d = {q_q[0].data, q_q[0].data};
                        mem_we_d  = q_q[0].addr[0] ? 2'b01 : 2'b10;
                    end
                    cnt_d   = LatInit;
                    state_d = StSpiAcc;
                end
            end
            StCpuAcc: begin
                if (cpu_as_n) begin
                    // Aborted cycle: any write is already committed, no ack.
                    cpu_served_d = 1'b0;
                    state_d      = StIdle;
                end else if (cnt_q == 2'd0) begin
                    if (cpu_rw) begin
                        cpu_din_d = mem_dout;
                    end
                    dtack_n_d    = 1'b0;
                    cpu_served_d = 1'b1;
                    state_d      = StCpuAck;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StCpuAck: begin
                if (cpu_as_n) begin
                    dtack_n_d    = 1'b1;
                    cpu_served_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            StSpiAcc: begin
                if (cnt_q == 2'd0) begin
                    if (!spi_op_wr_q) begin
                        spi_do_d       = spi_lsb_q ? mem_dout[7:0] : mem_dout[15:8];
                        spi_do_valid_d = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            cnt_q          <= 2'd0;
            cpu_served_q   <= 1'b0;
            dtack_n_q      <= 1'b1;
            cpu_din_q      <= 16'hFFFF;
            mem_addr_q     <= '0;
            mem_we_q       <= 2'b00;
            mem_din_q      <= 16'h0000;
            spi_do_q       <= 8'h00;
            spi_do_valid_q <= 1'b0;
            spi_ovf_q      <= 1'b0;
            spi_op_wr_q    <= 1'b0;
            spi_lsb_q      <= 1'b0;
            q_q            <= '0;
            q_cnt_q        <= 2'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cpu_served_q   <= cpu_served_d;
            dtack_n_q      <= dtack_n_d;
            cpu_din_q      <= cpu_din_d;
            mem_addr_q     <= mem_addr_d;
            mem_we_q       <= mem_we_d;
            mem_din_q      <= mem_din_d;
            spi_do_q       <= spi_do_d;
            spi_do_valid_q <= spi_do_valid_d;
            spi_ovf_q      <= spi_ovf_d;
            spi_op_wr_q    <= spi_op_wr_d;
            spi_lsb_q      <= spi_lsb_d;
            q_q            <= q_d;
            q_cnt_q        <= q_cnt_d;
        end
    end

    assign cpu_din      = cpu_din_q;
    assign dtack_n      = dtack_n_q;
    assign spi_do       = spi_do_q;
    assign spi_do_valid = spi_do_valid_q;
    assign spi_overflow = spi_ovf_q;
    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_din      = mem_din_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter
//
// Directed bench for cpu_mem_arbiter with default parameters (15-bit byte
// address, 1-cycle BRAM). A cycle table covers a CPU read and a CPU byte
// write; short hand-written sequences cover SPI queueing, overflow, page
// filtering, SPI reads, unmapped CPU accesses and reset during an SPI access.
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n;
    logic [23:1] cpu_a;
    logic [15:0] cpu_dout, cpu_din;
    logic        dtack_n;
    logic        spi_wr, spi_rd;
    logic [31:0] spi_addr;
    logic [7:0]  spi_di, spi_do;
    logic        spi_do_valid, spi_overflow;
    logic [13:0] mem_addr;
    logic [1:0]  mem_we;
    logic [15:0] mem_din, mem_dout;

    always #5 clk = ~clk;

    cpu_mem_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_as_n     (cpu_as_n),
        .cpu_rw       (cpu_rw),
        .cpu_uds_n    (cpu_uds_n),
        .cpu_lds_n    (cpu_lds_n),
        .cpu_a        (cpu_a),
        .cpu_dout     (cpu_dout),
        .cpu_din      (cpu_din),
        .dtack_n      (dtack_n),
        .spi_wr       (spi_wr),
        .spi_rd       (spi_rd),
        .spi_addr     (spi_addr),
        .spi_di       (spi_di),
        .spi_do       (spi_do),
        .spi_do_valid (spi_do_valid),
        .spi_overflow (spi_overflow),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    // BRAM model: one cycle read latency, byte write enables.
    logic [15:0] mem [0:16383];
    int          we_cnt = 0;
    int          vld_cnt = 0;

    always @(posedge clk) begin
        if (mem_we[1]) mem[mem_addr][15:8] <= mem_din[15:8];
        if (mem_we[0]) mem[mem_addr][7:0]  <= mem_din[7:0];
        mem_dout <= mem[mem_addr];
        if (mem_we != 2'b00) we_cnt <= we_cnt + 1;
        if (spi_do_valid) vld_cnt <= vld_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cpu(input logic as_n, input logic rw, input logic uds_n,
                           input logic lds_n, input logic [22:0] a, input logic [15:0] d);
        cpu_as_n  = as_n;
        cpu_rw    = rw;
        cpu_uds_n = uds_n;
        cpu_lds_n = lds_n;
        cpu_a     = a;
        cpu_dout  = d;
    endtask

    task automatic spi_pulse(input logic wr, input logic rd, input logic [31:0] a,
                             input logic [7:0] d);
        spi_wr   = wr;
        spi_rd   = rd;
        spi_addr = a;
        spi_di   = d;
        cyc(1);
        spi_wr   = 1'b0;
        spi_rd   = 1'b0;
    endtask

    task automatic wait_dtack(input logic lvl, input string name);
        int k = 0;
        while (dtack_n !== lvl && k < 20) begin
            cyc(1);
            k++;
        end
        if (dtack_n !== lvl) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: dtack_n timeout, got %b, expected %b", name, dtack_n, lvl);
        end
    endtask

    task automatic wait_we(input string name);
        int k = 0;
        while (mem_we == 2'b00 && k < 20) begin
            cyc(1);
            k++;
        end
        if (mem_we == 2'b00) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: mem_we timeout, got 00, expected nonzero", name);
        end
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (spi_do_valid !== 1'b1 && k < 20) begin
            cyc(1);
            k++;
        end
        if (spi_do_valid !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: spi_do_valid timeout, got 0, expected 1", name);
        end
    endtask

    // One row per clock: inputs applied, then outputs expected after the edge.
    typedef struct {
        logic        as_n, rw, uds_n, lds_n;
        logic [22:0] a;
        logic [15:0] dout;
        logic        exp_dtack_n;
        logic [1:0]  exp_we;
        logic        chk_addr;
        logic [13:0] exp_addr;
        logic        chk_din;
        logic [15:0] exp_din;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int vbase;

        // CPU word read of word 1, then a byte write to word 4.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 23'd1, 16'h0000, 1'b1, 2'b00, 1'b0, 14'd0, 1'b1, 16'hFFFF};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 23'd1, 16'h0000, 1'b1, 2'b00, 1'b1, 14'd1, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 23'd1, 16'h0000, 1'b1, 2'b00, 1'b1, 14'd1, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 23'd1, 16'h0000, 1'b0, 2'b00, 1'b1, 14'd1, 1'b1, 16'hBEEF};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 23'd1, 16'h0000, 1'b0, 2'b00, 1'b0, 14'd0, 1'b1, 16'hBEEF};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 23'd1, 16'h0000, 1'b1, 2'b00, 1'b0, 14'd0, 1'b1, 16'hBEEF};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 23'd4, 16'h1234, 1'b1, 2'b10, 1'b1, 14'd4, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 23'd4, 16'h1234, 1'b1, 2'b00, 1'b1, 14'd4, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 23'd4, 16'h1234, 1'b0, 2'b00, 1'b0, 14'd0, 1'b1, 16'hBEEF};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 23'd4, 16'h1234, 1'b1, 2'b00, 1'b0, 14'd0, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 23'd0, 16'h0000, 1'b1, 2'b00, 1'b0, 14'd0, 1'b0, 16'h0000};

        for (int i = 0; i < 16384; i++) mem[i] <= 16'h0000;
        #1;
        mem[1] <= 16'hBEEF;
        mem[4] <= 16'h0077;
        mem[5] <= 16'h5A3C;

        reset_n = 1'b0;
        set_cpu(1'b1, 1'b1, 1'b1, 1'b1, 23'd0, 16'h0000);
        spi_wr = 1'b0;
        spi_rd = 1'b0;
        spi_addr = 32'h0;
        spi_di = 8'h00;
        cyc(3);
        chk("reset dtack_n", 32'(dtack_n), 32'h1);
        chk("reset cpu_din", 32'(cpu_din), 32'hFFFF);
        chk("reset mem_we", 32'(mem_we), 32'h0);
        chk("reset spi_overflow", 32'(spi_overflow), 32'h0);
        chk("reset spi_do_valid", 32'(spi_do_valid), 32'h0);
        reset_n = 1'b1;
        cyc(1);

        // Table-driven CPU read and byte write.
        for (int i = 0; i < 11; i++) begin
            set_cpu(vecs[i].as_n, vecs[i].rw, vecs[i].uds_n, vecs[i].lds_n, vecs[i].a,
                    vecs[i].dout);
            cyc(1);
            chk($sformatf("vec%0d dtack_n", i), 32'(dtack_n), 32'(vecs[i].exp_dtack_n));
            chk($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
            if (vecs[i].chk_addr)
                chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
            if (vecs[i].chk_din)
                chk($sformatf("vec%0d cpu_din", i), 32'(cpu_din), 32'(vecs[i].exp_din));
        end
        chk("byte write mem[4]", 32'(mem[4]), 32'h1277);

        // Page filter: a request outside SPI_PAGE never reaches memory.
        base = we_cnt;
        spi_pulse(1'b1, 1'b0, 32'h0100_0020, 8'hFF);
        cyc(5);
        chk("page drop writes", 32'(we_cnt - base), 32'h0);
        chk("page drop overflow", 32'(spi_overflow), 32'h0);

        // SPI write queued during CPU_ACC, served after the CPU cycle.
        set_cpu(1'b0, 1'b1, 1'b0, 1'b0, 23'd1, 16'h0000);
        cyc(1);
        spi_pulse(1'b1, 1'b0, 32'h0000_0011, 8'hA5);
        chk("spi during cpu: no early we", 32'(mem_we), 32'h0);
        wait_dtack(1'b0, "spi during cpu ack");
        set_cpu(1'b1, 1'b1, 1'b1, 1'b1, 23'd1, 16'h0000);
        wait_we("spi queued write");
        chk("spi queued dtack_n", 32'(dtack_n), 32'h1);
        chk("spi queued mem_addr", 32'(mem_addr), 32'h8);
        chk("spi queued mem_we", 32'(mem_we), 32'h1);
        chk("spi queued mem_din", 32'(mem_din), 32'hA5A5);
        cyc(3);
        chk("spi queued mem[8]", 32'(mem[8]), 32'h00A5);

        // Overflow: three writes while the CPU sits in CPU_ACK.
        set_cpu(1'b0, 1'b1, 1'b0, 1'b0, 23'd2, 16'h0000);
        wait_dtack(1'b0, "overflow cpu ack");
        base = we_cnt;
        spi_pulse(1'b1, 1'b0, 32'h0000_0020, 8'h11);
        spi_pulse(1'b1, 1'b0, 32'h0000_0021, 8'h22);
        spi_pulse(1'b1, 1'b0, 32'h0000_0022, 8'h33);
        chk("overflow flag", 32'(spi_overflow), 32'h1);
        chk("overflow held off by cpu", 32'(we_cnt - base), 32'h0);
        set_cpu(1'b1, 1'b1, 1'b1, 1'b1, 23'd2, 16'h0000);
        cyc(12);
        chk("overflow write count", 32'(we_cnt - base), 32'h2);
        chk("overflow mem[0x10]", 32'(mem[16'h10]), 32'h1122);
        chk("overflow mem[0x11]", 32'(mem[16'h11]), 32'h0000);
        chk("overflow sticky", 32'(spi_overflow), 32'h1);

        // SPI reads of both byte lanes of word 5.
        vbase = vld_cnt;
        spi_pulse(1'b0, 1'b1, 32'h0000_000B, 8'h00);
        wait_valid("spi read odd");
        chk("spi read odd lane", 32'(spi_do), 32'h3C);
        cyc(5);
        chk("spi read one pulse", 32'(vld_cnt - vbase), 32'h1);
        spi_pulse(1'b0, 1'b1, 32'h0000_000A, 8'h00);
        wait_valid("spi read even");
        chk("spi read even lane", 32'(spi_do), 32'h5A);
        cyc(2);

        // Unmapped CPU access: immediate ack, open-bus data, no memory write.
        base = we_cnt;
        set_cpu(1'b0, 1'b0, 1'b0, 1'b0, 23'h40_0000, 16'h5555);
        cyc(1);
        chk("unmapped dtack_n", 32'(dtack_n), 32'h0);
        chk("unmapped cpu_din", 32'(cpu_din), 32'hFFFF);
        set_cpu(1'b1, 1'b1, 1'b1, 1'b1, 23'd0, 16'h0000);
        cyc(1);
        chk("unmapped release", 32'(dtack_n), 32'h1);
        cyc(2);
        chk("unmapped no write", 32'(we_cnt - base), 32'h0);

        // Reset during SPI_ACC with a second request still queued.
        set_cpu(1'b0, 1'b1, 1'b0, 1'b0, 23'd1, 16'h0000);
        wait_dtack(1'b0, "reset test cpu ack");
        spi_pulse(1'b1, 1'b0, 32'h0000_0030, 8'h77);
        spi_pulse(1'b1, 1'b0, 32'h0000_0031, 8'h88);
        set_cpu(1'b1, 1'b1, 1'b1, 1'b1, 23'd1, 16'h0000);
        wait_we("reset test spi access");
        reset_n = 1'b0;
        #1;
        chk("midreset dtack_n", 32'(dtack_n), 32'h1);
        chk("midreset cpu_din", 32'(cpu_din), 32'hFFFF);
        chk("midreset mem_we", 32'(mem_we), 32'h0);
        chk("midreset mem_addr", 32'(mem_addr), 32'h0);
        chk("midreset mem_din", 32'(mem_din), 32'h0);
        chk("midreset spi_do", 32'(spi_do), 32'h0);
        chk("midreset spi_overflow", 32'(spi_overflow), 32'h0);
        cyc(1);
        reset_n = 1'b1;
        base = we_cnt;
        cyc(8);
        chk("midreset queue empty", 32'(we_cnt - base), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
